// File: rtl/bus_handshakes_pkg.sv
// Shared definitions for the valid/ready handshake slices: skid FSM state codes,
// stall-counter width and a saturating increment helper.
package bus_handshakes_pkg;

    localparam logic PASS        = 1'b0;
    localparam logic SKID        = 1'b1;
    localparam int   STALL_CNT_W = 16;

    typedef enum logic {
        ST_PASS = PASS,
        ST_SKID = SKID
    } state_e;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] val);
        if (val == {STALL_CNT_W{1'b1}}) begin
            return val;
        end else begin
            return val + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/bus_handshakes_backward_registered.sv
// Backward-registered valid/ready slice: src_ready comes from a flop, and one beat is parked
// in a skid register while the sink stalls. Optional stall counter via BWD_REG_STALL_CNT_EN.
module bus_handshakes_backward_registered
    import bus_handshakes_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic                   clk,
    input  logic                   s_rst_n,
    input  logic                   src_vaild,
    input  logic [WIDTH-1:0]       src_data_in,
    output logic                   src_ready,
    output logic                   dst_vaild,
    output logic [WIDTH-1:0]       dst_data_out,
    input  logic                   dst_ready
`ifdef BWD_REG_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    state_e           state_q, state_d;
    logic             src_ready_q, src_ready_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             bypass_s;

    assign bypass_s  = src_vaild & src_ready_q;
    assign src_ready = src_ready_q;

    // Output mux: zero-latency bypass while the skid is empty, skid beat otherwise.
    always_comb begin
        dst_vaild    = 1'b0;
        dst_data_out = {WIDTH{1'b0}};
        case (state_q)
            ST_PASS: begin
                dst_vaild = bypass_s;
                if (bypass_s) begin
                    dst_data_out = src_data_in;
                end else begin
                    dst_data_out = {WIDTH{1'b0}};
                end
            end
            ST_SKID: begin
                dst_vaild    = 1'b1;
                dst_data_out = skid_data_q;
            end
            default: begin
                dst_vaild    = 1'b0;
                dst_data_out = {WIDTH{1'b0}};
            end
        endcase
    end

    // Next-state: park an accepted beat the sink refused, release it once the sink takes it.
    always_comb begin
        state_d     = state_q;
        skid_data_d = skid_data_q;
        case (state_q)
            ST_PASS: begin
                if (bypass_s && !dst_ready) begin
                    state_d     = ST_SKID;
                    skid_data_d = src_data_in;
                end else begin
                    state_d = ST_PASS;
                end
            end
            ST_SKID: begin
                if (dst_ready) begin
                    state_d = ST_PASS;
                end else begin
                    state_d = ST_SKID;
                end
            end
            default: begin
                state_d = ST_PASS;
            end
        endcase
        src_ready_d = (state_d == ST_PASS);
    end

    // State, registered ready and skid storage.
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q     <= ST_PASS;
            src_ready_q <= 1'b0;
            skid_data_q <= {WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            src_ready_q <= src_ready_d;
            skid_data_q <= skid_data_d;
        end
    end

`ifdef BWD_REG_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // A stall is a cycle where a beat is offered downstream but not taken.
    always_comb begin
        if (dst_vaild && !dst_ready) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Saturating stall counter register.
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            stall_cnt_q <= {STALL_CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bus_handshakes_backward_registered.sv
// Self-checking bench for the backward-registered skid slice: source -> DUT -> sink,
// with a scoreboard queue filled on source transfers and drained on sink transfers.
module tb_bus_handshakes_backward_registered;

    localparam int W = 9;

    logic         clk = 1'b0;
    logic         s_rst_n;
    logic         src_vaild;
    logic [W-1:0] src_data_in;
    logic         src_ready;
    logic         dst_vaild;
    logic [W-1:0] dst_data_out;
    logic         dst_ready;
`ifdef BWD_REG_STALL_CNT_EN
    logic [15:0]  stall_cnt;
`endif

    int           total_cnt = 0;
    int           bad_cnt   = 0;
    int           rx_cnt    = 0;
    logic         mon_en    = 1'b0;
    logic         src_fire_s = 1'b0;
    logic [W-1:0] sb[$];
    logic [W-1:0] exp_v;

    bus_handshakes_backward_registered #(.WIDTH(W)) dut (
        .clk          (clk),
        .s_rst_n      (s_rst_n),
        .src_vaild    (src_vaild),
        .src_data_in  (src_data_in),
        .src_ready    (src_ready),
        .dst_vaild    (dst_vaild),
        .dst_data_out (dst_data_out),
        .dst_ready    (dst_ready)
`ifdef BWD_REG_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor, sampled mid-cycle before the next rising edge.
    always @(negedge clk) begin
        src_fire_s = 1'b0;
        if (!s_rst_n) begin
            sb.delete();
        end else begin
            src_fire_s = src_vaild && src_ready;
            if (mon_en) begin
                if (sb.size() != 0) begin
                    check_val("skid_src_ready", {31'd0, src_ready}, 32'd0);
                    check_val("skid_dst_vaild", {31'd0, dst_vaild}, 32'd1);
                    check_val("skid_data", {23'd0, dst_data_out}, {23'd0, sb[0]});
                end
                if (src_fire_s) sb.push_back(src_data_in);
                if (dst_vaild && dst_ready) begin
                    if (sb.size() == 0) begin
                        check_val("sb_underflow", 32'(sb.size()), 32'd1);
                    end else begin
                        exp_v = sb.pop_front();
                        check_val("rx_data", {23'd0, dst_data_out}, {23'd0, exp_v});
                        rx_cnt++;
                    end
                end
            end
        end
    end

    // mode 0: sink always ready; mode 1: single stall on beat 0x011; other: toggling sink.
    task automatic run_beats(input logic [W-1:0] first, input int n, input int mode);
        int sent, budget, seg, phase, base;
        bit stalled;
        sent = 0; budget = 0; seg = 0; phase = 0; stalled = 1'b0;
        base = rx_cnt;
        @(posedge clk); #1;
        src_vaild   = 1'b1;
        src_data_in = first;
        while ((rx_cnt - base) < n && budget < 20000) begin
            case (mode)
                0: dst_ready = 1'b1;
                1: begin
                    if (!stalled && src_vaild && src_data_in == 9'h011) begin
                        dst_ready = 1'b0;
                        stalled   = 1'b1;
                        phase     = 1;
                    end else begin
                        dst_ready = 1'b1;
                    end
                end
                default: begin
                    if (seg == 0) begin
                        dst_ready = ~dst_ready;
                        seg = $urandom_range(2, 30);
                    end
                    seg--;
                end
            endcase
            #1;
            if (mode == 0 && src_vaild) begin
                check_val("stream_src_ready", {31'd0, src_ready}, 32'd1);
                check_val("stream_dst_vaild", {31'd0, dst_vaild}, 32'd1);
                check_val("stream_bypass", {23'd0, dst_data_out}, {23'd0, src_data_in});
            end
            if (mode == 1 && phase == 2) begin
                check_val("stall_src_ready", {31'd0, src_ready}, 32'd0);
                check_val("stall_hold_data", {23'd0, dst_data_out}, 32'h011);
            end
            if (mode == 1 && phase == 3) begin
                check_val("after_bubble_ready", {31'd0, src_ready}, 32'd1);
                check_val("after_bubble_data", {23'd0, dst_data_out}, 32'h012);
            end
            if (phase > 0) phase++;
            @(posedge clk); #1;
            budget++;
            if (src_fire_s) begin
                sent++;
                if (sent < n) src_data_in = first + W'(sent);
                else src_vaild = 1'b0;
            end
        end
        check_val("rx_count", 32'(rx_cnt - base), 32'(n));
        check_val("sb_empty", 32'(sb.size()), 32'd0);
        src_vaild = 1'b0;
        dst_ready = 1'b1;
    endtask

    initial begin
        s_rst_n     = 1'b0;
        src_vaild   = 1'b1;
        src_data_in = 9'h0AA;
        dst_ready   = 1'b1;

        // reset held 100 ns with a valid source beat present
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("rst_src_ready", {31'd0, src_ready}, 32'd0);
            check_val("rst_dst_vaild", {31'd0, dst_vaild}, 32'd0);
            check_val("rst_dst_data", {23'd0, dst_data_out}, 32'd0);
        end
        #2 s_rst_n = 1'b1;
        check_val("rel_src_ready_pre", {31'd0, src_ready}, 32'd0);
        @(posedge clk); #1;
        check_val("rel_src_ready", {31'd0, src_ready}, 32'd1);
        src_vaild = 1'b0;
        #1;
        check_val("idle_dst_data", {23'd0, dst_data_out}, 32'd0);
        mon_en = 1'b1;

        run_beats(9'h000, 256, 0);
        run_beats(9'h010, 16, 1);
        run_beats(9'h100, 256, 2);

        // park 0x1A5 in the skid, then reset asynchronously mid-cycle
        @(posedge clk); #1;
        src_vaild   = 1'b1;
        src_data_in = 9'h1A5;
        dst_ready   = 1'b0;
        @(posedge clk); #1;
        check_val("skid_1a5", {23'd0, dst_data_out}, 32'h1A5);
        #2;
        mon_en  = 1'b0;
        s_rst_n = 1'b0;
        #1;
        check_val("arst_dst_vaild", {31'd0, dst_vaild}, 32'd0);
        check_val("arst_src_ready", {31'd0, src_ready}, 32'd0);
        src_vaild = 1'b0;
        dst_ready = 1'b1;
        @(negedge clk);
        #2 s_rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("arst_rel_ready", {31'd0, src_ready}, 32'd1);
        mon_en = 1'b1;
        run_beats(9'h000, 8, 0);

`ifdef BWD_REG_STALL_CNT_EN
        mon_en = 1'b0;
        @(posedge clk); #1;
        s_rst_n = 1'b0;
        @(negedge clk);
        #2 s_rst_n = 1'b1;
        @(posedge clk); #1;
        src_vaild   = 1'b1;
        src_data_in = 9'h055;
        dst_ready   = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check_val("stall_cnt_7", {16'd0, stall_cnt}, 32'd7);
        s_rst_n = 1'b0;
        #1;
        check_val("stall_cnt_rst", {16'd0, stall_cnt}, 32'd0);
        @(negedge clk);
        #2 s_rst_n = 1'b1;
        repeat (70001) @(posedge clk);
        #1;
        check_val("stall_cnt_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
        src_vaild = 1'b0;
        dst_ready = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
